// File: rtl/prio_enc_rr.sv
// prio_enc_rr: registered priority encoder with sticky pending requests.
// Requests accumulate in a pending register. One grant index is presented
// at a time through a valid/ready handshake, selected either by fixed
// priority (highest index wins) or by round-robin from a rotating pointer.
module prio_enc_rr #(
   parameter  int WIDTH = 8,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic             mode,
   input  logic             ready,
   output logic             v,
   output logic [IDX_W-1:0] y,
   output logic [WIDTH-1:0] pending
);

   logic             fire;
   logic             load;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] pending_next;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_next;
   logic [IDX_W-1:0] fix_idx;
   logic [IDX_W-1:0] rr_idx;
   int               rr_j;

   // A grant is consumed when presented and accepted; its bit is cleared,
   // but a same-cycle re-request on that index keeps the bit set.
   assign fire         = v & ready;
   assign clr          = fire ? (WIDTH'(1) << y) : '0;
   assign pending_next = (pending & ~clr) | in;

   // Pointer moves to the slot after the accepted grant, wrapping at WIDTH-1
   // explicitly so non-power-of-two widths never reach an unused index.
   assign ptr_next = !fire ? ptr :
                     (y == IDX_W'(WIDTH - 1)) ? '0 : y + IDX_W'(1);

   // A presented grant is held until accepted; otherwise the output reloads.
   assign load = ~v | ready;

   // Fixed priority: highest set index of the next pending vector.
   always_comb begin
      fix_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (pending_next[IDX_W'(i)]) fix_idx = IDX_W'(i);
      end
   end

   // Round-robin: first set index at or after ptr_next, with wrap. The scan
   // runs from the farthest offset down so the nearest hit is kept last.
   always_comb begin
      rr_idx = '0;
      rr_j   = 0;
      for (int k = WIDTH - 1; k >= 0; k--) begin
         rr_j = int'(ptr_next) + k;
         if (rr_j >= WIDTH) rr_j = rr_j - WIDTH;
         if (pending_next[rr_j[IDX_W-1:0]]) rr_idx = rr_j[IDX_W-1:0];
      end
   end

   // State update: pending and pointer every cycle, grant only on load.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         ptr     <= '0;
         v       <= 1'b0;
         y       <= '0;
      end else begin
         pending <= pending_next;
         ptr     <= ptr_next;
         if (load) begin
            v <= |pending_next;
            y <= mode ? rr_idx : fix_idx;
         end
      end
   end

endmodule
